// File: rtl/pixel_sink_pkg.sv
// Shared types and default geometry for the pixel stream sink.
// Holds the FSM state encoding and a counter-width helper.
package pixel_sink_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sinkState_t;

    localparam int DEF_IMG_W  = 512;
    localparam int DEF_IMG_H  = 512;
    localparam int DEF_STRIDE = 512;
    localparam int DEF_ADDR_W = 20;

    // Counter width for a range 0..n-1, never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_stream_sink_if.sv
// Pixel stream (valid/ready) and frame-memory write port of the pixel sink.
// The sink uses the slave view; the upstream/memory side uses the master view.
interface pixel_stream_sink_if
    import pixel_sink_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              i_data_valid;
    logic [7:0]        i_data;
    logic              o_data_ready;
    logic              o_mem_wr_en;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        o_mem_wr_data;
    logic              i_mem_ready;

    modport slave (
        input  i_data_valid, i_data, i_mem_ready,
        output o_data_ready, o_mem_wr_en, o_mem_addr, o_mem_wr_data
    );

    modport master (
        output i_data_valid, i_data, i_mem_ready,
        input  o_data_ready, o_mem_wr_en, o_mem_addr, o_mem_wr_data
    );

endinterface

// File: rtl/sink_addr_gen.sv
// Raster address generator: column/row counters and line-start register.
// addr is the address the next accepted pixel will be written to.
module sink_addr_gen
    import pixel_sink_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int STRIDE = DEF_STRIDE,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] baseAddr,
    output logic [ADDR_W-1:0] addr,
    output logic              lastCol,
    output logic              lastPix
);

    localparam int COL_W = cntWidth(IMG_W);
    localparam int ROW_W = cntWidth(IMG_H);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] lineStart;
    logic [ADDR_W-1:0] nextLine;

    assign lastCol  = (col == COL_W'(IMG_W - 1));
    assign lastPix  = lastCol && (row == ROW_W'(IMG_H - 1));
    // Wraps modulo 2^ADDR_W by construction of the adder width.
    assign nextLine = lineStart + ADDR_W'(STRIDE);

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            col       <= '0;
            row       <= '0;
            lineStart <= '0;
            addr      <= '0;
        end else if (load) begin
            col       <= '0;
            row       <= '0;
            lineStart <= baseAddr;
            addr      <= baseAddr;
        end else if (advance) begin
            if (lastCol) begin
                col       <= '0;
                row       <= lastPix ? '0 : row + 1'b1;
                lineStart <= nextLine;
                addr      <= nextLine;
            end else begin
                col  <= col + 1'b1;
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_sink.sv
// Frame-memory sink for the blurred pixel stream: one in-flight write register,
// so a stalled memory turns directly into upstream backpressure.
module pixel_stream_sink
    import pixel_sink_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int STRIDE = DEF_STRIDE,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                axi_clk,
    input  logic                axi_reset_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [ADDR_W-1:0]   i_base_addr,
    pixel_stream_sink_if.slave  bus,
    output logic                o_busy,
    output logic                o_line_done,
    output logic                o_frame_done
);

    sinkState_t        state, nextState;
    logic              pend, pendLastCol, pendLastPix;
    logic [ADDR_W-1:0] pendAddr;
    logic [7:0]        pendData;
    logic              xfer, retire, startAcc;
    logic [ADDR_W-1:0] genAddr;
    logic              genLastCol, genLastPix;

    assign xfer     = bus.i_data_valid & bus.o_data_ready;
    assign retire   = pend & bus.i_mem_ready;
    assign startAcc = (state == IDLE) & i_start & ~i_abort;

    sink_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .STRIDE(STRIDE),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .axi_clk    (axi_clk),
        .axi_reset_n(axi_reset_n),
        .load       (startAcc),
        .advance    (xfer),
        .baseAddr   (i_base_addr),
        .addr       (genAddr),
        .lastCol    (genLastCol),
        .lastPix    (genLastPix)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) state <= IDLE;
        else              state <= nextState;
    end

    // NOTE: every output of a combinational process gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        nextState = state;
        if (i_abort) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_start)              nextState = RUN;
                RUN:     if (xfer && genLastPix)   nextState = DRAIN;
                DRAIN:   if (retire)               nextState = IDLE;
                default:                           nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.o_data_ready = 1'b0;
        o_busy           = 1'b0;
        case (state)
            RUN: begin
                o_busy           = 1'b1;
                bus.o_data_ready = ~pend | bus.i_mem_ready;
            end
            DRAIN:   o_busy = 1'b1;
            default: ;
        endcase
    end

    // A retiring write and a new transfer on the same edge simply reload the register.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            pend        <= 1'b0;
            pendLastCol <= 1'b0;
            pendLastPix <= 1'b0;
            pendAddr    <= '0;
            pendData    <= '0;
        end else if (i_abort) begin
            pend <= 1'b0;
        end else if (xfer) begin
            pend        <= 1'b1;
            pendLastCol <= genLastCol;
            pendLastPix <= genLastPix;
            pendAddr    <= genAddr;
            pendData    <= bus.i_data;
        end else if (retire) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            o_line_done  <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_line_done  <= retire & pendLastCol & ~i_abort;
            o_frame_done <= retire & pendLastPix & ~i_abort;
        end
    end

    assign bus.o_mem_wr_en   = pend;
    assign bus.o_mem_addr    = pendAddr;
    assign bus.o_mem_wr_data = pendData;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Scoreboard bench for pixel_stream_sink on a 4x3 frame with stride 8, 12-bit addresses.
// Driver pushes expected writes on each handshake; a negedge monitor pops and compares.
module tb_pixel_stream_sink;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int STRIDE = 8;
    localparam int ADDR_W = 12;
    localparam int NPIX   = IMG_W * IMG_H;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic              axi_clk;
    logic              axi_reset_n;
    logic              i_start;
    logic              i_abort;
    logic [ADDR_W-1:0] i_base_addr;
    logic              o_busy, o_line_done, o_frame_done;

    pixel_stream_sink_if #(.ADDR_W(ADDR_W)) bus ();

    pixel_stream_sink #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .STRIDE(STRIDE),
        .ADDR_W(ADDR_W)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_base_addr (i_base_addr),
        .bus         (bus.slave),
        .o_busy      (o_busy),
        .o_line_done (o_line_done),
        .o_frame_done(o_frame_done)
    );

    // Hand-computed address offsets for a 4-wide line on a stride of 8.
    int  offs [NPIX] = '{0, 1, 2, 3, 8, 9, 10, 11, 16, 17, 18, 19};
    wr_t expQ[$];

    int checks = 0, errors = 0;
    int cyc = 0, frameNo = 0, pixIdx = 0;
    int lineDoneCnt = 0, frameDoneCnt = 0, writeCnt = 0;
    int lastXferCyc = 0, frameDoneCyc = 0;
    logic [ADDR_W-1:0] curBase = '0;

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    always @(posedge axi_clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pixVal(input int idx);
        return 8'((idx * 37 + frameNo * 11 + 5) & 255);
    endfunction

    // Monitor: compares retiring writes against the scoreboard and checks stall rules.
    initial begin
        wr_t               e;
        logic              prevStall = 1'b0, prevAbort = 1'b0;
        logic [ADDR_W-1:0] prevAddr = '0;
        logic [7:0]        prevData = '0;
        forever begin
            @(negedge axi_clk);
            if (axi_reset_n) begin
                if (bus.o_mem_wr_en && bus.i_mem_ready) begin
                    writeCnt++;
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none",
                                 bus.o_mem_addr, bus.o_mem_wr_data);
                    end else begin
                        e = expQ.pop_front();
                        check("wr_addr", 32'(bus.o_mem_addr), 32'(e.addr));
                        check("wr_data", 32'(bus.o_mem_wr_data), 32'(e.data));
                    end
                end
                if (bus.o_mem_wr_en && !bus.i_mem_ready)
                    check("ready_low_in_stall", 32'(bus.o_data_ready), 0);
                if (!o_busy)
                    check("ready_low_when_idle", 32'(bus.o_data_ready), 0);
                if (prevStall && !prevAbort) begin
                    check("hold_wr_en", 32'(bus.o_mem_wr_en), 1);
                    check("hold_addr", 32'(bus.o_mem_addr), 32'(prevAddr));
                    check("hold_data", 32'(bus.o_mem_wr_data), 32'(prevData));
                end
                if (o_line_done) lineDoneCnt++;
                if (o_frame_done) begin
                    frameDoneCnt++;
                    frameDoneCyc = cyc;
                    check("idle_at_frame_done", 32'(o_busy), 0);
                end
            end
            prevStall = axi_reset_n && bus.o_mem_wr_en && !bus.i_mem_ready;
            prevAbort = i_abort;
            prevAddr  = bus.o_mem_addr;
            prevData  = bus.o_mem_wr_data;
        end
    end

    task automatic checkAllZero(input string tag);
        check({tag, "_ready"},      32'(bus.o_data_ready), 0);
        check({tag, "_wr_en"},      32'(bus.o_mem_wr_en), 0);
        check({tag, "_addr"},       32'(bus.o_mem_addr), 0);
        check({tag, "_wr_data"},    32'(bus.o_mem_wr_data), 0);
        check({tag, "_busy"},       32'(o_busy), 0);
        check({tag, "_line_done"},  32'(o_line_done), 0);
        check({tag, "_frame_done"}, 32'(o_frame_done), 0);
    endtask

    task automatic startFrame(input logic [ADDR_W-1:0] base);
        @(posedge axi_clk); #1;
        frameNo++;
        curBase          = base;
        i_start          = 1'b1;
        i_base_addr      = base;
        bus.i_data_valid = 1'b0;
        bus.i_mem_ready  = 1'b1;
        @(posedge axi_clk); #1;
        i_start     = 1'b0;
        i_base_addr = ~base;
        pixIdx      = 0;
    endtask

    // Offers pixels until n have been accepted; leaves time at posedge+1 after the last one.
    task automatic feed(input int n, input int vPct, input int rPct, input int midStartAt);
        int  budget = 0;
        wr_t e;
        while (pixIdx < n && budget < 400) begin
            bus.i_data_valid = (int'($urandom_range(99)) < vPct);
            bus.i_data       = pixVal(pixIdx);
            bus.i_mem_ready  = (int'($urandom_range(99)) < rPct);
            i_start          = (pixIdx == midStartAt);
            #1;
            if (bus.i_data_valid && bus.o_data_ready) begin
                e.addr = curBase + ADDR_W'(offs[pixIdx]);
                e.data = pixVal(pixIdx);
                expQ.push_back(e);
                lastXferCyc = cyc;
                pixIdx++;
            end
            @(posedge axi_clk); #1;
            budget++;
        end
        i_start = 1'b0;
        check("feed_complete", pixIdx, n);
    endtask

    task automatic runFrame(input logic [ADDR_W-1:0] base, input int vPct, input int rPct,
                            input int midStartAt);
        int l0 = lineDoneCnt, f0 = frameDoneCnt, w0 = writeCnt, budget = 0;
        startFrame(base);
        feed(NPIX, vPct, rPct, midStartAt);
        bus.i_data_valid = 1'b0;
        if (rPct == 100) begin
            // DRAIN cycle: the last write retires now and this i_start must be ignored.
            bus.i_mem_ready = 1'b1;
            i_start         = 1'b1;
            i_base_addr     = base;
            @(posedge axi_clk); #1;
            i_start = 1'b0;
            check("frame_done_pulse", 32'(o_frame_done), 1);
            check("busy_low_at_done", 32'(o_busy), 0);
            @(posedge axi_clk); #1;
            check("start_on_done_ignored", 32'(o_busy), 0);
            check("frame_done_one_cycle", 32'(o_frame_done), 0);
        end
        while (frameDoneCnt == f0 && budget < 200) begin
            @(posedge axi_clk); #1;
            bus.i_mem_ready = (int'($urandom_range(99)) < rPct);
            #5;
            budget++;
        end
        bus.i_mem_ready = 1'b1;
        check("frame_done_count", frameDoneCnt - f0, 1);
        check("line_done_count", lineDoneCnt - l0, IMG_H);
        check("write_count", writeCnt - w0, NPIX);
        check("scoreboard_empty", expQ.size(), 0);
        if (rPct == 100)
            check("frame_done_latency", frameDoneCyc - lastXferCyc, 2);
    endtask

    initial begin
        int l0, f0, w0;
        axi_reset_n      = 1'b0;
        i_start          = 1'b0;
        i_abort          = 1'b0;
        i_base_addr      = '0;
        bus.i_data_valid = 1'b0;
        bus.i_data       = '0;
        bus.i_mem_ready  = 1'b0;
        #3;
        checkAllZero("reset");
        #9 axi_reset_n = 1'b1;

        // Pixels offered before start are never accepted.
        @(posedge axi_clk); #1;
        bus.i_data_valid = 1'b1;
        bus.i_data       = 8'h55;
        bus.i_mem_ready  = 1'b1;
        repeat (5) begin
            #1;
            check("ready_before_start", 32'(bus.o_data_ready), 0);
            check("no_write_before_start", 32'(bus.o_mem_wr_en), 0);
            @(posedge axi_clk); #1;
        end
        bus.i_data_valid = 1'b0;

        runFrame(12'h000, 100, 100, -1);
        runFrame(12'h100, 100, 100, 5);
        runFrame(12'hFF8, 100, 100, -1);
        runFrame(12'h020, 60, 50, -1);
        runFrame(12'h7A0, 40, 50, -1);

        // Abort with pixel 10 pending and memory stalled.
        l0 = lineDoneCnt; f0 = frameDoneCnt; w0 = writeCnt;
        startFrame(12'h040);
        feed(11, 100, 100, -1);
        bus.i_data_valid = 1'b0;
        bus.i_mem_ready  = 1'b0;
        i_abort          = 1'b1;
        @(posedge axi_clk); #1;
        i_abort = 1'b0;
        expQ.delete();
        check("abort_busy", 32'(o_busy), 0);
        check("abort_drops_write", 32'(bus.o_mem_wr_en), 0);
        bus.i_data_valid = 1'b1;
        bus.i_mem_ready  = 1'b1;
        repeat (4) begin
            #1;
            check("ready_after_abort", 32'(bus.o_data_ready), 0);
            @(posedge axi_clk); #1;
        end
        bus.i_data_valid = 1'b0;
        check("abort_line_done", lineDoneCnt - l0, 2);
        check("abort_no_frame_done", frameDoneCnt - f0, 0);
        check("abort_writes", writeCnt - w0, 10);
        runFrame(12'h200, 100, 100, -1);

        // Asynchronous reset mid-frame with pixel 6 pending.
        w0 = writeCnt;
        startFrame(12'h300);
        feed(7, 100, 100, -1);
        axi_reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        expQ.delete();
        check("midreset_writes", writeCnt - w0, 6);
        bus.i_data_valid = 1'b0;
        @(posedge axi_clk); #1;
        axi_reset_n = 1'b1;
        runFrame(12'h000, 100, 100, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
